// File: rtl/alu_pkg.sv
// alu_pkg: op encodings, select width and sequencer state encoding shared by the ALU op sequencer.
package alu_pkg;
    localparam int SEL_W = 5;

    typedef enum logic [SEL_W-1:0] {
        ALU_OP_ADD = 5'd0,
        ALU_OP_SUB = 5'd1,
        ALU_OP_DIV = 5'd2,
        ALU_OP_AND = 5'd3,
        ALU_OP_OR  = 5'd4,
        ALU_OP_XOR = 5'd5
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } seq_state_e;

    function automatic logic op_legal(input logic [SEL_W-1:0] op);
        return op <= ALU_OP_XOR;
    endfunction

    function automatic logic op_has_carry(input logic [SEL_W-1:0] op);
        return op == ALU_OP_ADD || op == ALU_OP_SUB;
    endfunction
endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: request, ALU-side and response signals of the op sequencer.
// ALU_SEQ_FLAGS_EN adds the rsp_zero/rsp_neg flag lines.
interface alu_op_sequencer_if
    import alu_pkg::*;
#(
    parameter int WORD_SIZE = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic [SEL_W-1:0]     req_op;
    logic [WORD_SIZE-1:0] req_a;
    logic [WORD_SIZE-1:0] req_b;
    logic [WORD_SIZE-1:0] alu_a;
    logic [WORD_SIZE-1:0] alu_b;
    logic [SEL_W-1:0]     alu_sel;
    logic [WORD_SIZE-1:0] alu_result;
    logic                 alu_carry;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [WORD_SIZE-1:0] rsp_z;
    logic                 rsp_carry;
    logic                 rsp_err;
`ifdef ALU_SEQ_FLAGS_EN
    logic                 rsp_zero;
    logic                 rsp_neg;
`endif

    modport master (
        input  req_valid, req_op, req_a, req_b, alu_result, alu_carry, rsp_ready,
        output req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_z, rsp_carry, rsp_err
`ifdef ALU_SEQ_FLAGS_EN
        , rsp_zero, rsp_neg
`endif
    );

    modport slave (
        output req_valid, req_op, req_a, req_b, alu_result, alu_carry, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_z, rsp_carry, rsp_err
`ifdef ALU_SEQ_FLAGS_EN
        , rsp_zero, rsp_neg
`endif
    );
endinterface

// File: rtl/alu_settle_counter.sv
// alu_settle_counter: loadable down-counter that times the ALU settle window.
module alu_settle_counter #(
    parameter int DIV_WAIT = 4,
    localparam int W = $clog2(DIV_WAIT) + 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt;

    assign zero = cnt == '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec && !zero) cnt <= cnt - W'(1);
    end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives a combinational ALU for one op at a time, waits for settle, returns the Z register.
// ALU_SEQ_FLAGS_EN adds registered rsp_zero/rsp_neg flags.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int DIV_WAIT  = 4
) (
    input logic                 clk,
    input logic                 reset_n,
    alu_op_sequencer_if.master  bus
);
    localparam int CW = $clog2(DIV_WAIT) + 1;

    seq_state_e           state;
    logic                 cnt_zero;
    logic [CW-1:0]        load_val;
    logic                 accept;
    logic [WORD_SIZE-1:0] cap_z;
    logic                 cap_carry;
    logic                 cap_err;

    assign accept   = state == ST_IDLE && bus.req_valid && bus.req_ready;
    assign load_val = bus.req_op == ALU_OP_DIV ? CW'(DIV_WAIT - 1) : '0;

    alu_settle_counter #(.DIV_WAIT(DIV_WAIT)) u_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (accept),
        .load_val (load_val),
        .dec      (state == ST_SETTLE),
        .zero     (cnt_zero)
    );

    // Divide-by-zero reports all ones regardless of what the ALU produced
    always_comb begin
        cap_err   = !op_legal(bus.alu_sel) || (bus.alu_sel == ALU_OP_DIV && bus.alu_b == '0);
        cap_z     = !op_legal(bus.alu_sel) ? '0 : cap_err ? '1 : bus.alu_result;
        cap_carry = op_has_carry(bus.alu_sel) && bus.alu_carry;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            bus.req_ready <= 1'b0;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_sel   <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_z     <= '0;
            bus.rsp_carry <= 1'b0;
            bus.rsp_err   <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
            bus.rsp_zero  <= 1'b0;
            bus.rsp_neg   <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    bus.req_ready <= 1'b1;
                    if (accept) begin
                        bus.alu_a     <= bus.req_a;
                        bus.alu_b     <= bus.req_b;
                        bus.alu_sel   <= bus.req_op;
                        bus.req_ready <= 1'b0;
                        state         <= ST_SETTLE;
                    end
                end
                ST_SETTLE: if (cnt_zero) begin
                    bus.rsp_z     <= cap_z;
                    bus.rsp_carry <= cap_carry;
                    bus.rsp_err   <= cap_err;
`ifdef ALU_SEQ_FLAGS_EN
                    bus.rsp_zero  <= cap_z == '0;
                    bus.rsp_neg   <= cap_z[WORD_SIZE-1];
`endif
                    bus.rsp_valid <= 1'b1;
                    state         <= ST_RESP;
                end
                ST_RESP: if (bus.rsp_ready) begin
                    bus.rsp_valid <= 1'b0;
                    bus.req_ready <= 1'b1;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: vector table, random ops against a reference model, backpressure and mid-op reset.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int WS = 32;
    localparam int DW = 4;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
        logic        c;
        logic        e;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int total = 0;
    int bad = 0;
    logic [31:0] alu_r;
    logic        alu_c;

    always #5 clk = ~clk;

    alu_op_sequencer_if #(.WORD_SIZE(WS)) bus ();

    alu_op_sequencer #(.WORD_SIZE(WS), .DIV_WAIT(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Stand-in ALU; carry and result are deliberately junk where the sequencer must ignore them
    always_comb begin
        alu_r = 32'hDEAD_BEEF;
        alu_c = 1'b1;
        case (bus.alu_sel)
            5'd0: begin alu_r = bus.alu_a + bus.alu_b; alu_c = alu_r < bus.alu_a; end
            5'd1: begin alu_r = bus.alu_a - bus.alu_b; alu_c = bus.alu_a < bus.alu_b; end
            5'd2: alu_r = bus.alu_b == 0 ? 32'h1234_5678 : bus.alu_a / bus.alu_b;
            5'd3: alu_r = bus.alu_a & bus.alu_b;
            5'd4: alu_r = bus.alu_a | bus.alu_b;
            5'd5: alu_r = bus.alu_a ^ bus.alu_b;
            default: ;
        endcase
    end
    assign bus.alu_result = alu_r;
    assign bus.alu_carry  = alu_c;

    function automatic vec_t model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        vec_t v;
        logic [32:0] w;
        v.op = op; v.a = a; v.b = b; v.z = 0; v.c = 0; v.e = 0;
        v.lat = op == 5'd2 ? DW : 1;
        if (op > 5) v.e = 1;
        else if (op == 5'd2 && b == 0) begin v.z = 32'hFFFF_FFFF; v.e = 1; end
        else if (op == 5'd0) begin w = {1'b0, a} + {1'b0, b}; v.z = w[31:0]; v.c = w[32]; end
        else if (op == 5'd1) begin w = {1'b0, a} - {1'b0, b}; v.z = w[31:0]; v.c = w[32]; end
        else if (op == 5'd2) v.z = a / b;
        else if (op == 5'd3) v.z = a & b;
        else if (op == 5'd4) v.z = a | b;
        else v.z = a ^ b;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        while (!bus.req_ready && n < 50) begin @(posedge clk); #1; n++; end
        check("req_ready before issue", 32'(bus.req_ready), 1);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
        logic stable = 1'b1;
        lat = 0;
        while (!bus.rsp_valid && lat < 50) begin
            if (bus.alu_a !== a || bus.alu_b !== b || bus.alu_sel !== op) stable = 1'b0;
            @(posedge clk); #1; lat++;
        end
        check("alu lines stable in settle", 32'(stable), 1);
    endtask

    task automatic finish_rsp();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check("rsp_valid drops after handshake", 32'(bus.rsp_valid), 0);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        issue(v.op, v.a, v.b);
        wait_rsp(v.op, v.a, v.b, lat);
        check($sformatf("latency op%0d", v.op), 32'(lat), 32'(v.lat));
        check($sformatf("rsp_z op%0d", v.op), bus.rsp_z, v.z);
        check($sformatf("rsp_carry op%0d", v.op), 32'(bus.rsp_carry), 32'(v.c));
        check($sformatf("rsp_err op%0d", v.op), 32'(bus.rsp_err), 32'(v.e));
`ifdef ALU_SEQ_FLAGS_EN
        check("rsp_zero", 32'(bus.rsp_zero), 32'(v.z == 0));
        check("rsp_neg", 32'(bus.rsp_neg), 32'(v.z[31]));
`endif
        finish_rsp();
    endtask

    initial begin
        vec_t tbl[10];
        vec_t v;
        int lat;
        tbl[0] = '{5'd0, 32'hFFFF_FFFF, 32'd1,      32'h0000_0000, 1'b1, 1'b0, 1};
        tbl[1] = '{5'd1, 32'd5,         32'd7,      32'hFFFF_FFFE, 1'b1, 1'b0, 1};
        tbl[2] = '{5'd3, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 1};
        tbl[3] = '{5'd2, 32'd100,       32'd7,      32'd14,        1'b0, 1'b0, 4};
        tbl[4] = '{5'd2, 32'd5,         32'd0,      32'hFFFF_FFFF, 1'b0, 1'b1, 4};
        tbl[5] = '{5'd9, 32'd1,         32'd2,      32'h0000_0000, 1'b0, 1'b1, 1};
        tbl[6] = '{5'd4, 32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1'b0, 1'b0, 1};
        tbl[7] = '{5'd5, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0, 1'b0, 1'b0, 1};
        tbl[8] = '{5'd0, 32'd3,         32'd4,      32'd7,         1'b0, 1'b0, 1};
        tbl[9] = '{5'd6, 32'd8,         32'd8,      32'h0000_0000, 1'b0, 1'b1, 1};

        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        check("reset req_ready", 32'(bus.req_ready), 0);
        check("reset rsp_valid", 32'(bus.rsp_valid), 0);
        check("reset alu_a", bus.alu_a, 0);
        check("reset alu_sel", 32'(bus.alu_sel), 0);
        check("reset rsp_z", bus.rsp_z, 0);
        check("reset rsp_err", 32'(bus.rsp_err), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("req_ready after release", 32'(bus.req_ready), 1);

        for (int i = 0; i < 10; i++) run_vec(tbl[i]);

        for (int i = 0; i < 40; i++) begin
            logic [4:0]  op;
            logic [31:0] a, b;
            op = 5'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 2)) : $urandom;
            run_vec(model(op, a, b));
        end

        // Backpressure: response must hold and a second request must wait for the handshake
        issue(5'd0, 32'd2, 32'd3);
        wait_rsp(5'd0, 32'd2, 32'd3, lat);
        check("bp first rsp_z", bus.rsp_z, 32'd5);
        bus.req_valid = 1'b1; bus.req_op = 5'd5; bus.req_a = 32'd12; bus.req_b = 32'd3;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp rsp_valid held", 32'(bus.rsp_valid), 1);
            check("bp rsp_z held", bus.rsp_z, 32'd5);
            check("bp req_ready low", 32'(bus.req_ready), 0);
            check("bp alu_sel held", 32'(bus.alu_sel), 0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check("bp handshake rsp_valid", 32'(bus.rsp_valid), 0);
        check("bp handshake req_ready", 32'(bus.req_ready), 1);
        check("bp no accept at handshake", 32'(bus.alu_sel), 0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("bp second accepted sel", 32'(bus.alu_sel), 5);
        check("bp second accepted a", bus.alu_a, 32'd12);
        wait_rsp(5'd5, 32'd12, 32'd3, lat);
        check("bp second latency", 32'(lat), 1);
        check("bp second rsp_z", bus.rsp_z, 32'd15);
        finish_rsp();

        // Reset in the middle of a divide settle window
        issue(5'd2, 32'd100, 32'd7);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        check("mid reset alu_a", bus.alu_a, 0);
        check("mid reset alu_b", bus.alu_b, 0);
        check("mid reset alu_sel", 32'(bus.alu_sel), 0);
        check("mid reset rsp_z", bus.rsp_z, 0);
        check("mid reset req_ready", 32'(bus.req_ready), 0);
        check("mid reset rsp_valid", 32'(bus.rsp_valid), 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("in reset rsp_valid", 32'(bus.rsp_valid), 0);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("post reset rsp_valid", 32'(bus.rsp_valid), 0);
        run_vec(tbl[3]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
